// File: rtl/axis_pkg.sv
// Shared sizing helpers for the AXI4-Stream width converters.
// A wide beat is packed as {data, keep, last}; these functions size each field.
package axis_pkg;

  function automatic int unsigned keep_width(input int unsigned data_width);
    return data_width / 8;
  endfunction

  function automatic int unsigned beat_width(input int unsigned data_width);
    return data_width + keep_width(data_width) + 1;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// One-entry skid buffer in front of an output register.
// o_ready is a pure flop output, so downstream ready never reaches upstream combinationally.
module axis_skid_buffer #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             i_aclk,
  input  logic             i_aresetn,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_skid_valid;
  logic [WIDTH-1:0] r_skid_data;
  logic             w_out_free;
  logic             w_in_fire;

  assign w_out_free = !r_out_valid | i_ready;
  assign w_in_fire  = i_valid & !r_skid_valid;

  always_ff @(posedge i_aclk) begin
    if (!i_aresetn) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_skid_valid <= 1'b0;
    end else if (w_out_free) begin
      // The skid entry is always older than anything on the input.
      if (r_skid_valid) begin
        r_out_valid  <= 1'b1;
        r_out_data   <= r_skid_data;
        r_skid_valid <= 1'b0;
      end else begin
        r_out_valid <= w_in_fire;
        if (w_in_fire) begin
          r_out_data <= i_data;
        end
      end
    end else if (w_in_fire) begin
      r_skid_valid <= 1'b1;
    end
  end

  always_ff @(posedge i_aclk) begin
    if (!w_out_free && w_in_fire) begin
      r_skid_data <= i_data;
    end
  end

  assign o_ready = !r_skid_valid;
  assign o_valid = r_out_valid;
  assign o_data  = r_out_data;

endmodule

// File: rtl/axis_upsizer.sv
// AXI4-Stream width upsizer: packs RATIO narrow beats into one wide beat, flushing on tlast.
// Define AXIS_UPSIZER_SKID_EN to register s_tready behind a one-entry skid buffer.
module axis_upsizer
  import axis_pkg::*;
#(
  parameter int unsigned S_DATA_WIDTH = 64,
  parameter int unsigned RATIO        = 4
) (
  input  logic                                     aclk,
  input  logic                                     aresetn,
  input  logic                                     s_tvalid,
  output logic                                     s_tready,
  input  logic [S_DATA_WIDTH-1:0]                  s_tdata,
  input  logic [keep_width(S_DATA_WIDTH)-1:0]       s_tkeep,
  input  logic                                     s_tlast,
  output logic                                     m_tvalid,
  input  logic                                     m_tready,
  output logic [S_DATA_WIDTH*RATIO-1:0]            m_tdata,
  output logic [keep_width(S_DATA_WIDTH*RATIO)-1:0] m_tkeep,
  output logic                                     m_tlast
);

  localparam int unsigned M_DATA_WIDTH = S_DATA_WIDTH * RATIO;
  localparam int unsigned S_KEEP_WIDTH = keep_width(S_DATA_WIDTH);
  localparam int unsigned M_KEEP_WIDTH = keep_width(M_DATA_WIDTH);
  localparam int unsigned IDX_WIDTH    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(RATIO - 1);

  typedef struct packed {
    logic [M_DATA_WIDTH-1:0] data;
    logic [M_KEEP_WIDTH-1:0] keep;
    logic                    last;
  } wide_beat_t;

  logic [IDX_WIDTH-1:0]    r_idx;
  logic [M_DATA_WIDTH-1:0] r_acc_data;
  logic [M_KEEP_WIDTH-1:0] r_acc_keep;
  logic                    w_completing;
  logic                    w_s_fire;
  logic                    w_load;
  logic                    w_m_valid;
  wide_beat_t              w_beat;
  wide_beat_t              w_m_beat;

  assign w_completing = (r_idx == LAST_IDX) | s_tlast;
  assign w_s_fire     = s_tvalid & s_tready;
  assign w_load       = w_s_fire & w_completing;

  // Lanes below idx come from the accumulator, lane idx is the live beat, the rest are empty.
  always_comb begin
    w_beat = '0;
    for (int unsigned l = 0; l < RATIO; l++) begin
      if (IDX_WIDTH'(l) < r_idx) begin
        w_beat.data[l*S_DATA_WIDTH +: S_DATA_WIDTH] = r_acc_data[l*S_DATA_WIDTH +: S_DATA_WIDTH];
        w_beat.keep[l*S_KEEP_WIDTH +: S_KEEP_WIDTH] = r_acc_keep[l*S_KEEP_WIDTH +: S_KEEP_WIDTH];
      end else if (IDX_WIDTH'(l) == r_idx) begin
        w_beat.data[l*S_DATA_WIDTH +: S_DATA_WIDTH] = s_tdata;
        w_beat.keep[l*S_KEEP_WIDTH +: S_KEEP_WIDTH] = s_tkeep;
      end
    end
    w_beat.last = s_tlast;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_idx      <= '0;
      r_acc_keep <= '0;
    end else if (w_s_fire) begin
      if (w_completing) begin
        r_idx      <= '0;
        r_acc_keep <= '0;
      end else begin
        r_idx <= r_idx + IDX_WIDTH'(1);
        for (int unsigned l = 0; l < RATIO; l++) begin
          if (r_idx == IDX_WIDTH'(l)) begin
            r_acc_keep[l*S_KEEP_WIDTH +: S_KEEP_WIDTH] <= s_tkeep;
          end
        end
      end
    end
  end

  // Data lanes need no reset: lanes at or above idx are never read.
  always_ff @(posedge aclk) begin
    if (w_s_fire && !w_completing) begin
      for (int unsigned l = 0; l < RATIO; l++) begin
        if (r_idx == IDX_WIDTH'(l)) begin
          r_acc_data[l*S_DATA_WIDTH +: S_DATA_WIDTH] <= s_tdata;
        end
      end
    end
  end

`ifdef AXIS_UPSIZER_SKID_EN
  logic                                w_skid_ready;
  logic [beat_width(M_DATA_WIDTH)-1:0] w_m_flat;

  assign s_tready = aresetn & w_skid_ready;

  axis_skid_buffer #(
    .WIDTH(beat_width(M_DATA_WIDTH))
  ) u_skid (
    .i_aclk   (aclk),
    .i_aresetn(aresetn),
    .i_valid  (w_load),
    .o_ready  (w_skid_ready),
    .i_data   (w_beat),
    .o_valid  (w_m_valid),
    .i_ready  (m_tready),
    .o_data   (w_m_flat)
  );

  assign w_m_beat = w_m_flat;
`else
  logic       r_m_valid;
  wide_beat_t r_m_beat;
  logic       w_out_free;

  // Only the completing beat needs a free output register.
  assign w_out_free = !r_m_valid | m_tready;
  assign s_tready   = aresetn & (w_out_free | !w_completing);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_m_valid <= 1'b0;
      r_m_beat  <= '0;
    end else if (w_out_free) begin
      r_m_valid <= w_load;
      if (w_load) begin
        r_m_beat <= w_beat;
      end
    end
  end

  assign w_m_valid = r_m_valid;
  assign w_m_beat  = r_m_beat;
`endif

  assign m_tvalid = w_m_valid;
  assign m_tdata  = w_m_beat.data;
  assign m_tkeep  = w_m_beat.keep;
  assign m_tlast  = w_m_beat.last;

endmodule

// File: tb/tb_axis_upsizer.sv
// Self-checking bench for axis_upsizer (S_DATA_WIDTH=64, RATIO=4), scoreboard based.
module tb_axis_upsizer;

  localparam int unsigned SW    = 64;
  localparam int unsigned RATIO = 4;
  localparam int unsigned MW    = SW * RATIO;
  localparam int unsigned SK    = SW / 8;
  localparam int unsigned MK    = MW / 8;

  typedef struct packed {
    logic [MW-1:0] data;
    logic [MK-1:0] keep;
    logic          last;
  } exp_t;

  logic          aclk     = 1'b0;
  logic          aresetn  = 1'b0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [SW-1:0] s_tdata  = '0;
  logic [SK-1:0] s_tkeep  = '0;
  logic          s_tlast  = 1'b0;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic [MW-1:0] m_tdata;
  logic [MK-1:0] m_tkeep;
  logic          m_tlast;

  exp_t          q[$];
  int            n_cmp = 0;
  int            n_fail = 0;
  int            mdl_idx = 0;
  logic [MW-1:0] mdl_data = '0;
  logic [MK-1:0] mdl_keep = '0;
  logic          rnd_ready_en = 1'b0;
  logic          prev_stall = 1'b0;
  exp_t          prev_out;

  always #5 aclk = ~aclk;

  axis_upsizer #(
    .S_DATA_WIDTH(SW),
    .RATIO       (RATIO)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_tvalid(s_tvalid),
    .s_tready(s_tready),
    .s_tdata (s_tdata),
    .s_tkeep (s_tkeep),
    .s_tlast (s_tlast),
    .m_tvalid(m_tvalid),
    .m_tready(m_tready),
    .m_tdata (m_tdata),
    .m_tkeep (m_tkeep),
    .m_tlast (m_tlast)
  );

  always @(posedge aclk) begin
    if (rnd_ready_en) begin
      #1;
      m_tready = 1'($urandom_range(0, 1));
    end
  end

  // Scoreboard pop on every master transfer, plus hold-stable check on every stall.
  always @(negedge aclk) begin
    exp_t e;
    if (aresetn !== 1'b1) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        n_cmp++;
        if (m_tvalid !== 1'b1 || {m_tdata, m_tkeep, m_tlast} !== prev_out) begin
          n_fail++;
          $display("FAIL stall_hold: got valid=%b keep=%h last=%b data=%h, want valid=1 keep=%h last=%b data=%h",
                   m_tvalid, m_tkeep, m_tlast, m_tdata, prev_out.keep, prev_out.last, prev_out.data);
        end
      end
      if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard_extra: got data=%h keep=%h last=%b, want no beat",
                   m_tdata, m_tkeep, m_tlast);
        end else begin
          e = q.pop_front();
          if ({m_tdata, m_tkeep, m_tlast} !== e) begin
            n_fail++;
            $display("FAIL scoreboard: got data=%h keep=%h last=%b, want data=%h keep=%h last=%b",
                     m_tdata, m_tkeep, m_tlast, e.data, e.keep, e.last);
          end
        end
      end
      prev_stall = (m_tvalid === 1'b1) && (m_tready === 1'b0);
      prev_out   = {m_tdata, m_tkeep, m_tlast};
    end
  end

  task automatic model_accept(input logic [SW-1:0] d, input logic [SK-1:0] k, input logic l);
    mdl_data[mdl_idx*SW +: SW] = d;
    mdl_keep[mdl_idx*SK +: SK] = k;
    if (l || mdl_idx == RATIO - 1) begin
      q.push_back('{data: mdl_data, keep: mdl_keep, last: l});
      mdl_data = '0;
      mdl_keep = '0;
      mdl_idx  = 0;
    end else begin
      mdl_idx++;
    end
  endtask

  task automatic model_reset();
    mdl_data = '0;
    mdl_keep = '0;
    mdl_idx  = 0;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_beat(input logic [SW-1:0] d, input logic [SK-1:0] k, input logic l,
                           output int waited);
    waited   = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    @(negedge aclk);
    while (s_tready !== 1'b1 && waited < 200) begin
      @(negedge aclk);
      waited++;
    end
    if (s_tready !== 1'b1) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: got s_tready=%b after %0d cycles, want 1", s_tready, waited);
    end else begin
      model_accept(d, k, l);
    end
    @(posedge aclk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic test_reset();
    aresetn  = 1'b0;
    m_tready = 1'b0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    n_cmp += 5;
    if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b want 0", m_tvalid); end
    if (m_tkeep !== '0) begin n_fail++; $display("FAIL reset_tkeep: got %h want 0", m_tkeep); end
    if (m_tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast: got %b want 0", m_tlast); end
    if (m_tdata !== '0) begin n_fail++; $display("FAIL reset_tdata: got %h want 0", m_tdata); end
    if (s_tready !== 1'b0) begin n_fail++; $display("FAIL reset_tready: got %b want 0", s_tready); end
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    model_reset();
  endtask

  task automatic test_full_packet();
    logic [SW-1:0] pat[4];
    logic [MW-1:0] want;
    int w;
    pat[0] = {8{8'h11}};
    pat[1] = {8{8'h22}};
    pat[2] = {8{8'h33}};
    pat[3] = {8{8'h44}};
    want = {pat[3], pat[2], pat[1], pat[0]};
    m_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_beat(pat[i], 8'hFF, (i == 3), w);
      n_cmp++;
      if (w != 0) begin n_fail++; $display("FAIL full_throughput: beat %0d waited %0d want 0", i, w); end
    end
    @(negedge aclk);
    n_cmp += 4;
    if (m_tvalid !== 1'b1) begin n_fail++; $display("FAIL full_latency: got tvalid=%b want 1", m_tvalid); end
    if (m_tdata !== want) begin n_fail++; $display("FAIL full_data: got %h want %h", m_tdata, want); end
    if (m_tkeep !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL full_keep: got %h want ffffffff", m_tkeep); end
    if (m_tlast !== 1'b1) begin n_fail++; $display("FAIL full_last: got %b want 1", m_tlast); end
  endtask

  task automatic test_partial();
    logic [127:0] want_lo;
    int w;
    want_lo = {{8{8'hBB}}, {8{8'hAA}}};
    @(posedge aclk);
    #1;
    send_beat({8{8'hAA}}, 8'hFF, 1'b0, w);
    send_beat({8{8'hBB}}, 8'hFF, 1'b1, w);
    @(negedge aclk);
    n_cmp += 4;
    if (m_tdata[MW-1:128] !== '0) begin n_fail++; $display("FAIL partial_upper: got %h want 0", m_tdata[MW-1:128]); end
    if (m_tdata[127:0] !== want_lo) begin n_fail++; $display("FAIL partial_lower: got %h want %h", m_tdata[127:0], want_lo); end
    if (m_tkeep !== 32'h0000_FFFF) begin n_fail++; $display("FAIL partial_keep: got %h want 0000ffff", m_tkeep); end
    if (m_tlast !== 1'b1) begin n_fail++; $display("FAIL partial_last: got %b want 1", m_tlast); end
  endtask

  task automatic test_backpressure();
    int w;
    @(posedge aclk);
    #1;
    m_tready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      send_beat({8{8'(8'h01 + i)}}, 8'hFF, 1'b0, w);
      n_cmp++;
      if (w != 0) begin n_fail++; $display("FAIL bp_absorb: beat %0d waited %0d want 0", i, w); end
    end
    fork
      begin
        repeat (5) @(posedge aclk);
        #1;
        m_tready = 1'b1;
      end
      begin
        send_beat({8{8'h08}}, 8'hFF, 1'b0, w);
`ifdef AXIS_UPSIZER_SKID_EN
        n_cmp++;
        if (w != 0) begin n_fail++; $display("FAIL bp_skid_accept: waited %0d want 0", w); end
        @(negedge aclk);
        n_cmp++;
        if (s_tready !== 1'b0) begin n_fail++; $display("FAIL bp_skid_full: got s_tready=%b want 0", s_tready); end
`else
        n_cmp++;
        if (w != 5) begin n_fail++; $display("FAIL bp_stall: beat 8 waited %0d want 5", w); end
`endif
      end
    join
    repeat (4) @(posedge aclk);
    @(negedge aclk);
    n_cmp += 2;
    if (q.size() != 0) begin n_fail++; $display("FAIL bp_drain: got %0d pending want 0", q.size()); end
    if (s_tready !== 1'b1) begin n_fail++; $display("FAIL bp_ready: got s_tready=%b want 1", s_tready); end
  endtask

  task automatic test_reset_mid_packet();
    int w;
    @(posedge aclk);
    #1;
    m_tready = 1'b1;
    send_beat({8{8'hE1}}, 8'hFF, 1'b0, w);
    send_beat({8{8'hE2}}, 8'hFF, 1'b0, w);
    aresetn = 1'b0;
    model_reset();
    @(negedge aclk);
    n_cmp++;
    if (s_tready !== 1'b0) begin n_fail++; $display("FAIL midrst_tready: got %b want 0", s_tready); end
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_beat({8{8'(8'hC0 + i)}}, 8'hFF, (i == 3), w);
    end
    @(negedge aclk);
    n_cmp += 2;
    if (m_tvalid !== 1'b1) begin n_fail++; $display("FAIL midrst_valid: got %b want 1", m_tvalid); end
    if (m_tdata[SW-1:0] !== {8{8'hC0}}) begin
      n_fail++;
      $display("FAIL midrst_lane0: got %h want %h", m_tdata[SW-1:0], {8{8'hC0}});
    end
  endtask

  task automatic test_random_stream();
    int w;
    int guard;
    @(posedge aclk);
    #1;
    rnd_ready_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge aclk);
        #1;
      end
      send_beat({$urandom, $urandom}, 8'($urandom), (i == 399) || ($urandom_range(0, 4) == 0), w);
    end
    rnd_ready_en = 1'b0;
    @(posedge aclk);
    #1;
    m_tready = 1'b1;
    guard = 0;
    while (q.size() != 0 && guard < 50) begin
      @(negedge aclk);
      guard++;
    end
    @(negedge aclk);
    n_cmp += 2;
    if (q.size() != 0) begin n_fail++; $display("FAIL random_drain: got %0d pending want 0", q.size()); end
    if (mdl_idx != 0) begin n_fail++; $display("FAIL random_model_idx: got %0d want 0", mdl_idx); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, got running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_packet();
    test_partial();
    test_backpressure();
    test_reset_mid_packet();
    test_random_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
